// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - state encoding, size defaults and helpers for prog_loader (optional PROG_LOADER_CHECKSUM_EN)
package prog_loader_pkg;

  // Default program store: 32 instruction words addressed by 5 bits.
  localparam int PL_DEPTH  = 32;
  localparam int PL_ADDR_W = 5;

  // Download sequencer states; CHK only exists when the trailing checksum byte is compiled in.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
`ifdef PROG_LOADER_CHECKSUM_EN
    ST_CHK,
`endif
    ST_RUN,
    ST_ERR
  } pl_state_e;

  // A length byte is usable when it names at least one word and fits the program store.
  function automatic logic len_in_range(input logic [7:0] len, input int depth);
    return (len != 8'd0) && (int'(len) <= depth);
  endfunction

  // States in which the loader owns the CPU program store and consumes stream bytes.
  function automatic logic is_loading(input pl_state_e st);
    logic r;
    r = 1'b0;
    case (st)
      ST_LEN, ST_DATA: r = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CHK: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program downloader feeding a CPU instruction store (PROG_LOADER_CHECKSUM_EN adds a checksum byte)
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DEPTH  = PL_DEPTH,
  parameter int ADDR_W = PL_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              load,
  output logic [7:0]        load_data,
  output logic [ADDR_W-1:0] load_addr,
  output logic              load_we,
  output logic              cpu_run,
  output logic              err
);

  // The word counter is one bit wider than the address so it can hold L == DEPTH
  // without the address field ever wrapping.
  localparam int CNT_W = ADDR_W + 1;

  pl_state_e          state_q, state_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic [7:0]         load_data_q, load_data_d;
  logic [ADDR_W-1:0]  load_addr_q, load_addr_d;
  logic               load_we_q, load_we_d;
  logic               load_q, load_d;
  logic               cpu_run_q, cpu_run_d;
  logic               err_q, err_d;
  logic               in_ready_q, in_ready_d;
  logic               accept;
  logic               last_word;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]         sum_q, sum_d;
`endif

  assign accept    = in_valid && in_ready_q;
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign last_word = (cnt_inc == len_q);

  // Next-state, datapath and registered-output computation for the download sequencer.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    load_data_d = load_data_q;
    load_addr_d = load_addr_q;
    load_we_d   = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif

    case (state_q)
      ST_IDLE, ST_RUN: begin
        // A fresh download (or a reload from RUN) restarts the address stream at 0.
        if (start) begin
          state_d     = ST_LEN;
          cnt_d       = '0;
          load_addr_d = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d       = 8'd0;
`endif
        end
      end

      ST_LEN: begin
        if (accept) begin
          if (len_in_range(in_data, DEPTH)) begin
            state_d = ST_DATA;
            len_d   = in_data[CNT_W-1:0];
          end else begin
            state_d = ST_ERR;
          end
        end
      end

      ST_DATA: begin
        if (accept) begin
          load_we_d   = 1'b1;
          load_data_d = in_data;
          load_addr_d = cnt_q[ADDR_W-1:0];
          cnt_d       = cnt_inc;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d       = sum_q + in_data;
          if (last_word) state_d = ST_CHK;
`else
          if (last_word) state_d = ST_RUN;
`endif
        end
      end

`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (accept) begin
          state_d = (in_data == sum_q) ? ST_RUN : ST_ERR;
        end
      end
`endif

      ST_ERR: begin
        state_d = ST_ERR;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state. load is stretched over the final
    // write pulse, and cpu_run waits until that pulse is gone so the two never overlap.
    in_ready_d = is_loading(state_d);
    load_d     = is_loading(state_d) || load_we_d;
    cpu_run_d  = (state_d == ST_RUN) && !load_we_d;
    err_d      = (state_d == ST_ERR);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      load_data_q <= 8'd0;
      load_addr_q <= '0;
      load_we_q   <= 1'b0;
      load_q      <= 1'b0;
      cpu_run_q   <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      load_data_q <= load_data_d;
      load_addr_q <= load_addr_d;
      load_we_q   <= load_we_d;
      load_q      <= load_d;
      cpu_run_q   <= cpu_run_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign load      = load_q;
  assign load_data = load_data_q;
  assign load_addr = load_addr_q;
  assign load_we   = load_we_q;
  assign cpu_run   = cpu_run_q;
  assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard bench for prog_loader (follows PROG_LOADER_CHECKSUM_EN if defined)
module tb_prog_loader;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  typedef struct {
    int         addr;
    logic [7:0] data;
  } wr_t;

  logic              clock;
  logic              reset;
  logic              start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              load;
  logic [7:0]        load_data;
  logic [ADDR_W-1:0] load_addr;
  logic              load_we;
  logic              cpu_run;
  logic              err;

  int  total = 0;
  int  bad   = 0;
  wr_t exp_q[$];
  logic [7:0] dq[$];
  bit  m_run = 0;
  bit  m_err = 0;

  prog_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .load      (load),
    .load_data (load_data),
    .load_addr (load_addr),
    .load_we   (load_we),
    .cpu_run   (cpu_run),
    .err       (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write pulse is popped against the scoreboard; load/cpu_run exclusion checked every cycle.
  always @(negedge clock) begin
    if (load && cpu_run) begin
      total++;
      bad++;
      $display("FAIL load_run_excl: load=%0d cpu_run=%0d at %0t", load, cpu_run, $time);
    end
    if (load_we) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: addr=%0d data=%0h at %0t", load_addr, load_data, $time);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (int'(load_addr) != e.addr || load_data != e.data || !load) begin
          bad++;
          $display("FAIL write: got (%0d,%0h,load=%0d) expected (%0d,%0h,load=1) at %0t",
                   load_addr, load_data, load, e.addr, e.data, $time);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    @(negedge clock);
    reset = 1'b0;
    chk("rst_load", load, 0);
    chk("rst_load_we", load_we, 0);
    chk("rst_cpu_run", cpu_run, 0);
    chk("rst_err", err, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_load_data", load_data, 0);
    chk("rst_load_addr", load_addr, 0);
    m_run = 0;
    m_err = 0;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1; in_valid = 1'b0;
    @(negedge clock);
    start = 1'b0;
    if (m_err) begin
      chk("err_hold_start", err, 1);
      chk("err_no_load", load, 0);
      chk("err_no_ready", in_ready, 0);
    end else begin
      chk("start_load", load, 1);
      chk("start_run_drop", cpu_run, 0);
      chk("start_ready", in_ready, 1);
    end
  endtask

  // Offer one byte after gap idle cycles (gap<0: random 0..3); returns once it is accepted.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit noise);
    int g;
    int t;
    g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
    repeat (g) begin
      @(negedge clock);
      in_valid = 1'b0; start = 1'b0; in_data = 8'($urandom);
    end
    @(negedge clock);
    in_valid = 1'b1; in_data = b;
    start = noise && ($urandom_range(0, 5) == 0);
    t = 0;
    while (!in_ready) begin
      if (t > 50) begin
        total++; bad++;
        $display("FAIL ready_timeout: in_ready=0 for %0d cycles at %0t", t, $time);
        break;
      end
      t++;
      @(negedge clock);
    end
    @(posedge clock);
  endtask

  task automatic settle();
    @(negedge clock);
    in_valid = 1'b0; start = 1'b0;
    repeat (3) @(negedge clock);
    chk("sb_empty", exp_q.size(), 0);
    chk("end_cpu_run", cpu_run, int'(m_run));
    chk("end_err", err, int'(m_err));
    chk("end_load", load, 0);
    chk("end_ready", in_ready, 0);
  endtask

  // Reference: a valid length yields writes (i, data[i]); outcome RUN unless length or checksum is bad.
  task automatic download(input logic [7:0] len, input int gap, input logic [7:0] sum_xor);
    logic [7:0] s;
    wr_t w;
    s = 8'd0;
    pulse_start();
    send_byte(len, gap, 1'b0);
    if (len == 8'd0 || int'(len) > DEPTH) begin
      m_run = 0; m_err = 1;
    end else begin
      for (int i = 0; i < int'(len); i++) begin
        w.addr = i;
        w.data = dq[i];
        exp_q.push_back(w);
        s = s + dq[i];
        send_byte(dq[i], gap, 1'b1);
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      send_byte(s ^ sum_xor, gap, 1'b0);
      m_run = (sum_xor == 8'd0);
      m_err = (sum_xor != 8'd0);
`else
      m_run = 1; m_err = 0;
`endif
    end
    settle();
  endtask

  task automatic rand_data();
    dq.delete();
    for (int i = 0; i < DEPTH; i++) dq.push_back(8'($urandom));
  endtask

  initial begin
    wr_t w;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clock);
    do_reset();

    // Basic three-word program, back to back.
    dq = '{8'hA1, 8'hB2, 8'hC3};
    download(8'h03, 0, 8'h00);

    // Reload from RUN with a single word.
    dq = '{8'h55};
    download(8'h01, 0, 8'h00);

    // Zero length and over-long length both lock in ERR until reset.
    do_reset();
    dq.delete();
    download(8'h00, 0, 8'h00);
    pulse_start();
    settle();
    do_reset();
    download(8'h21, 0, 8'h00);

    // Full-depth program with in_valid toggling every other cycle.
    do_reset();
    rand_data();
    download(8'h20, 1, 8'h00);

`ifdef PROG_LOADER_CHECKSUM_EN
    do_reset();
    dq = '{8'h10, 8'h20};
    download(8'h02, 0, 8'h00);
    do_reset();
    download(8'h02, 0, 8'h01);
`endif

    // Reset after the second of four words aborts the download.
    do_reset();
    dq = '{8'h11, 8'h22, 8'h33, 8'h44};
    pulse_start();
    send_byte(8'h04, 0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      w.addr = i; w.data = dq[i];
      exp_q.push_back(w);
      send_byte(dq[i], 0, 1'b0);
    end
    do_reset();
    @(negedge clock);
    in_valid = 1'b1; in_data = 8'h33;
    repeat (4) @(negedge clock);
    in_valid = 1'b0;
    chk("abort_ready", in_ready, 0);
    chk("abort_sb_empty", exp_q.size(), 0);

    // Randomized downloads: mostly legal lengths, occasional illegal lengths and bad checksums.
    for (int n = 0; n < 40; n++) begin
      logic [7:0] len;
      logic [7:0] sx;
      if (m_err || !m_run || $urandom_range(0, 3) == 0) do_reset();
      rand_data();
      if ($urandom_range(0, 7) == 0)
        len = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(DEPTH + 1, 255));
      else
        len = 8'($urandom_range(1, DEPTH));
      sx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      download(len, -1, sx);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
